// File: rtl/keypad_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
//
// Shared definitions for the keypad front end:
//   - state_t      : scanner / debouncer state encoding
//   - KEY_CODE_W   : width of an emitted hex key code
//   - KEY_MAP      : 16-entry (row, col) -> hex code table, indexed {row, col}
//   - lowest_row() : priority pick of the lowest active row line
//   - key_lookup() : table lookup wrapper for a latched (row, col) pair
// ---------------------------------------------------------------------------
package keypad_pkg;

    localparam int KEY_CODE_W = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Physical keypad legend. Row 3 carries '*' (E), '0', '#' (F) and 'D'.
    localparam logic [KEY_CODE_W-1:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    // When several rows are active in the same column the lowest index wins.
    function automatic logic [1:0] lowest_row(input logic [3:0] rows);
        if (rows[0]) begin
            return 2'd0;
        end else if (rows[1]) begin
            return 2'd1;
        end else if (rows[2]) begin
            return 2'd2;
        end else begin
            return 2'd3;
        end
    endfunction

    function automatic logic [KEY_CODE_W-1:0] key_lookup(input logic [1:0] row,
                                                         input logic [1:0] col);
        return KEY_MAP[{row, col}];
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//
// Two-flop synchroniser for asynchronous level inputs (keypad rows, panel
// switches). Each bit is synchronised independently, so a multi-bit bus is
// only safe for signals whose bits may be sampled on different cycles.
//
// Parameters:
//   WIDTH  number of independent bits
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset, clears both stages
//   d      asynchronous input
//   q      synchronised output, two clk cycles behind d
// ---------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First stage may go metastable; only the second stage is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan_debounce.sv
// ---------------------------------------------------------------------------
// keypad_scan_debounce
//
// Scans a 4x4 hex keypad one column at a time, debounces a press and its
// release, and emits a hex code with a one-cycle valid strobe per press.
// key_code/key_valid feed the register-bank write data/enable downstream.
//
// Parameters:
//   SCAN_DIV      cycles each column stays selected while scanning (>= 3)
//   DEBOUNCE_CNT  stable cycles needed to accept a press and a release
//   REPEAT_CNT    autorepeat period in cycles (autorepeat build only)
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   row_in     keypad row lines, active-high, for the column on col_sel
//   col_sel    column currently driven
//   key_code   hex code of the last accepted key
//   key_valid  one-cycle strobe when key_code is (re)issued
//   key_held   high while an accepted key remains pressed
//
// Build option:
//   KEYPAD_AUTOREPEAT_EN  when defined, a held key re-strobes key_valid every
//                         REPEAT_CNT cycles; when undefined, one strobe per
//                         press and no repeat counter exists.
// ---------------------------------------------------------------------------
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV     = 16'd1000,
    parameter logic [15:0] DEBOUNCE_CNT = 16'd5000,
    parameter logic [23:0] REPEAT_CNT   = 24'd2_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            row_in,
    output logic [1:0]            col_sel,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_valid,
    output logic                  key_held
);

    localparam int DIV_W = $clog2(int'(SCAN_DIV) + 1);
    localparam int CNT_W = $clog2(int'(DEBOUNCE_CNT) + 1);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 16'd1);
    localparam logic [DIV_W-1:0] DIV_GUARD = DIV_W'(2);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CNT - 16'd1);

    // A misconfigured instance (too short a scan window, zero-length
    // debounce or repeat period) never leaves SCAN instead of misbehaving.
    localparam logic PARAMS_VALID = (SCAN_DIV >= 16'd3) &&
                                    (DEBOUNCE_CNT != 16'd0) &&
                                    (REPEAT_CNT != 24'd0);

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = $clog2(int'(REPEAT_CNT) + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CNT - 24'd1);

    logic [REP_W-1:0] rep_q;
    logic [REP_W-1:0] rep_d;
`endif

    state_t                state_q;
    state_t                state_d;
    logic [1:0]            col_q;
    logic [1:0]            col_d;
    logic [DIV_W-1:0]      div_q;
    logic [DIV_W-1:0]      div_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic [1:0]            row_q;
    logic [1:0]            row_d;
    logic [KEY_CODE_W-1:0] code_q;
    logic [KEY_CODE_W-1:0] code_d;
    logic                  valid_q;
    logic                  valid_d;
    logic                  held_q;
    logic                  held_d;

    logic [3:0]            row_s;
    logic                  row_hit;

    sync_2ff #(
        .WIDTH (4)
    ) u_row_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (row_in),
        .q     (row_s)
    );

    // While a key is being tracked col_sel is frozen, so the latched row
    // alone identifies the line to watch.
    assign row_hit = row_s[row_q];

    // State and datapath registers; everything clears asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCAN;
            col_q   <= 2'd0;
            div_q   <= '0;
            cnt_q   <= '0;
            row_q   <= 2'd0;
            code_q  <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            held_q  <= held_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

    // Next-state logic. key_valid defaults low so every strobe lasts exactly
    // one cycle; key_code only moves on the cycle that raises the strobe.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        code_d  = code_q;
        valid_d = 1'b0;
        held_d  = held_q;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d   = rep_q;
`endif

        case (state_q)
            SCAN: begin
                // The first two cycles of a column still show the previous
                // column's rows through the synchroniser, hence the guard.
                if ((row_s != 4'd0) && (div_q >= DIV_GUARD) && PARAMS_VALID) begin
                    row_d   = lowest_row(row_s);
                    cnt_d   = '0;
                    div_d   = '0;
                    state_d = DEBOUNCE;
                end else if (div_q == DIV_LAST) begin
                    div_d = '0;
                    col_d = col_q + 2'd1;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            DEBOUNCE: begin
                if (!row_hit) begin
                    // Bounce: resume scanning in the same column, fresh window.
                    cnt_d   = '0;
                    div_d   = '0;
                    state_d = SCAN;
                end else if (cnt_q == CNT_LAST) begin
                    code_d  = key_lookup(row_q, col_q);
                    valid_d = 1'b1;
                    held_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_d   = '0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            PRESSED: begin
                if (!row_hit) begin
                    cnt_d   = '0;
                    state_d = RELEASE;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_d   = '0;
`endif
                end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
                    if (rep_q == REP_LAST) begin
                        valid_d = 1'b1;
                        rep_d   = '0;
                    end else begin
                        rep_d = rep_q + REP_W'(1);
                    end
`endif
                end
            end

            RELEASE: begin
`ifdef KEYPAD_AUTOREPEAT_EN
                rep_d = '0;
`endif
                if (row_hit) begin
                    // Release bounce: still the same press, so no new strobe.
                    cnt_d   = '0;
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    held_d  = 1'b0;
                    cnt_d   = '0;
                    div_d   = '0;
                    state_d = SCAN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = SCAN;
            end
        endcase
    end

    assign col_sel   = col_q;
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// ---------------------------------------------------------------------------
// tb_keypad_scan_debounce
//
// Keypad matrix model drives row_in from a set of pressed keys and the DUT's
// col_sel. Each press pushes its expected strobes (code and arrival cycle)
// into a scoreboard queue; a separate monitor pops and compares whenever
// key_valid is seen.
// ---------------------------------------------------------------------------
module tb_keypad_scan_debounce;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 8;
    localparam int REP      = 40;

    logic       clk;
    logic       rst_n;
    logic [3:0] row_in;
    logic [1:0] col_sel;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    // Pressed keys, bit index row*4 + col.
    logic [15:0] key_down;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    typedef struct {
        logic [3:0] code;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [3:0] last_code;
    logic [3:0] prev_code;
    logic [3:0] ref_map [4][4];

    keypad_scan_debounce #(
        .SCAN_DIV     (16'd4),
        .DEBOUNCE_CNT (16'd8),
        .REPEAT_CNT   (24'd40)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_in    (row_in),
        .col_sel   (col_sel),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // A pressed key closes its row line only while its column is driven.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_in[r] = key_down[r * 4 + int'(col_sel)];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic timeoutFail(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    function automatic int lowestRow(input logic [3:0] mask);
        for (int r = 0; r < 4; r++) begin
            if (mask[r]) return r;
        end
        return 0;
    endfunction

    // Press the keys in 'mask' on column 'col' just before that column comes
    // round, and return the cycle at which the column became active.
    task automatic pressAligned(input logic [3:0] mask, input int col, output int c0);
        int guard;
        guard = 0;
        while (int'(col_sel) != (col + 3) % 4 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) timeoutFail("align_prev_col");
        for (int r = 0; r < 4; r++) begin
            if (mask[r]) key_down[r * 4 + col] = 1'b1;
        end
        guard = 0;
        while (int'(col_sel) != col && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 40) timeoutFail("align_col");
        c0 = cyc;
    endtask

    // Model: a press seen for at least DEB+1 cycles is accepted 2 sync
    // cycles + 1 detect cycle + DEB cycles after the column arrives; with
    // autorepeat each further REP cycles of holding adds one strobe.
    task automatic applyStimulus(input logic [3:0] mask, input int col, input int hold);
        int         c0;
        int         n_strobes;
        logic [3:0] code;
        bit         accepted;
        exp_t       e;
        accepted = (hold >= DEB + 1);
        code     = ref_map[lowestRow(mask)][col];
        pressAligned(mask, col, c0);
        if (accepted) begin
            n_strobes = 1;
`ifdef KEYPAD_AUTOREPEAT_EN
            n_strobes += (hold - (DEB + 1)) / REP;
`endif
            for (int k = 0; k < n_strobes; k++) begin
                e.code = code;
                e.cyc  = c0 + DEB + 3 + k * REP;
                sb.push_back(e);
            end
        end
        repeat (hold) @(negedge clk);
        if (accepted) checkOutput("col_frozen", {30'd0, col_sel}, col);
        key_down = '0;
        if (accepted) begin
            repeat (5) @(negedge clk);
            checkOutput("held_during_release", {31'd0, key_held}, 1);
            repeat (8) @(negedge clk);
            checkOutput("held_after_release", {31'd0, key_held}, 0);
            checkOutput("code_after_press", {28'd0, key_code}, {28'd0, code});
            last_code = code;
        end else begin
            repeat (4) @(negedge clk);
            checkOutput("scan_resume_col", {30'd0, col_sel}, col);
            checkOutput("held_after_bounce", {31'd0, key_held}, 0);
            checkOutput("code_after_bounce", {28'd0, key_code}, {28'd0, last_code});
        end
        repeat (6) @(negedge clk);
    endtask

    // After reset release (at a negedge) the column advances every SCAN_DIV.
    task automatic checkScanSequence(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput("scan_col", {30'd0, col_sel}, ((i + 1) / SCAN_DIV) % 4);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_code = key_code;
        end else begin
            if (key_valid) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_strobe: got key_valid with code %0h, expected none (cycle %0d)", key_code, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("strobe_code", {28'd0, key_code}, {28'd0, mon_e.code});
                    checkOutput("strobe_cycle", cyc, mon_e.cyc);
                end
            end else begin
                checkOutput("code_stable", {28'd0, key_code}, {28'd0, prev_code});
            end
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                mon_e = sb.pop_front();
                compared++;
                mismatched++;
                $display("[TB] FAIL missing_strobe: got none, expected code %0h at cycle %0d", mon_e.code, mon_e.cyc);
            end
            prev_code = key_code;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0;
        exp_t e;
        ref_map = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                    '{4'h4, 4'h5, 4'h6, 4'hB},
                    '{4'h7, 4'h8, 4'h9, 4'hC},
                    '{4'hE, 4'h0, 4'hF, 4'hD}};
        key_down  = '0;
        last_code = 4'h0;
        rst_n     = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset_col", {30'd0, col_sel}, 0);
        checkOutput("reset_code", {28'd0, key_code}, 0);
        checkOutput("reset_valid", {31'd0, key_valid}, 0);
        checkOutput("reset_held", {31'd0, key_held}, 0);
        rst_n = 1'b1;
        $display("[TB] reset released, checking idle scan");
        checkScanSequence(20);

        $display("[TB] press bounce at col 0");
        applyStimulus(4'b0001, 0, 3);

        $display("[TB] clean press of key 6");
        applyStimulus(4'b0010, 2, 30);

        $display("[TB] release bounce on key 6");
        pressAligned(4'b0010, 2, c0);
        e.code = 4'h6;
        e.cyc  = c0 + DEB + 3;
        sb.push_back(e);
        repeat (20) @(negedge clk);
        key_down = '0;
        repeat (3) @(negedge clk);
        key_down[1 * 4 + 2] = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("held_rebounce", {31'd0, key_held}, 1);
        checkOutput("col_rebounce", {30'd0, col_sel}, 2);
        key_down = '0;
        repeat (5) @(negedge clk);
        checkOutput("held_rebounce_release", {31'd0, key_held}, 1);
        repeat (8) @(negedge clk);
        checkOutput("held_rebounce_done", {31'd0, key_held}, 0);
        last_code = 4'h6;
        repeat (6) @(negedge clk);

        $display("[TB] multiple rows and row 3 keys");
        applyStimulus(4'b0101, 0, 20);
        applyStimulus(4'b1000, 0, 20);
        applyStimulus(4'b1000, 2, 20);

        $display("[TB] async reset during debounce");
        pressAligned(4'b0010, 1, c0);
        repeat (6) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_col", {30'd0, col_sel}, 0);
        checkOutput("async_code", {28'd0, key_code}, 0);
        checkOutput("async_valid", {31'd0, key_valid}, 0);
        checkOutput("async_held", {31'd0, key_held}, 0);
        key_down  = '0;
        last_code = 4'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checkScanSequence(17);

        $display("[TB] randomized presses");
        for (int i = 0; i < 20; i++) begin
            logic [3:0] m;
            int         c;
            int         h;
            m = 4'($urandom_range(1, 15));
            c = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) h = $urandom_range(DEB + 4, 38);
            else                           h = $urandom_range(1, DEB - 2);
            applyStimulus(m, c, h);
        end

`ifdef KEYPAD_AUTOREPEAT_EN
        $display("[TB] autorepeat hold of key 9");
        applyStimulus(4'b0100, 2, 130);
`endif

        repeat (20) @(negedge clk);
        checkOutput("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
